jtframe_ddio_bidir: RTL and testbench
=====================================

Name: jtframe_ddio_bidir

Overview:
- Parametrised double-data-rate bidirectional pad model for Pocket target simulation; successor to the fixed 12-bit DDIO model.
- Adds the following:
  - width parameter
  - registered output path
  - both-edge input capture, realigned to the rising edge
  - direction state machine with a programmable bus-turnaround guard and request/acknowledge handshake
- Sits between core memory/video controllers and the top-level pad bus.

Parameters:
W, 12, pad/data width in bits
TURN, 1, idle (tri-stated, no capture) cycles inserted on every direction change; 0..15

Ports:
clk  input  1  single clock; rising and falling edges both used
rst_n  input  1  asynchronous reset, active low
oe_req  input  1  1 = request to drive pad, 0 = request to receive
oe_ack  output  1  1 = block is driving pad (state OUT)
datain_h  input  W  data driven during clk high phase
datain_l  input  W  data driven during clk low phase
dataout_h  output  W  pad value sampled at rising edge
dataout_l  output  W  pad value sampled at following falling edge
dout_vld  output  1  dataout_h/l pair captured entirely in state IN
contention  output  1  sticky error flag (see Optional Feature)
padio  inout  W  bidirectional pad

Behaviour:
- Reset (rst_n low, async):
  - state=IN; oe_ack=0; dout_vld=0; contention=0
  - dataout_h/l=0; internal h_r/l_r/capture regs=0
  - padio tri-stated immediately, not at next edge.
- Output path:
  - datain_h/l are registered into h_r/l_r at each rising edge; 1-cycle latency.
  - In state OUT, padio = h_r while clk=1 and l_r while clk=0. In all other states padio = all-z.
- Input capture:
  - rise_q <= padio at posedge; fall_q <= padio at negedge.
  - At posedge: dataout_h <= rise_q, dataout_l <= fall_q. Pad value at posedge n reaches dataout_h at posedge n+1.
- dout_vld=1 at posedge n+1 only if state was IN at posedge n and at the following negedge. Otherwise 0; dataout_h/l still update.
- FSM states, evaluated at posedge:
  - IN: oe_req=1 -> TURN_OUT (cnt=0), or directly OUT if TURN=0.
  - TURN_OUT: oe_req=0 -> IN (abort, bus was never driven). When cnt==TURN-1 -> OUT. Otherwise cnt++.
  - OUT: oe_req=0 -> TURN_IN (cnt=0), or IN if TURN=0.
  - TURN_IN: always completes; oe_req ignored. When cnt==TURN-1 -> IN, then oe_req is re-evaluated the next cycle.
- oe_ack = (state==OUT), registered; it rises the same posedge padio starts driving.
- Latency:
  - oe_req rising while in IN gives oe_ack=1 after TURN+1 posedges.
  - oe_req falling while in OUT gives pad released after 1 posedge and IN entered after TURN+1 posedges.
- Data driven in the first OUT cycle is datain sampled at the posedge that entered OUT.
- Turnaround counter is 4 bits and saturates; TURN>15 is a parameter error, flagged via $error at elaboration.
- Mid-operation reset returns to IN with the pad released asynchronously; no partial turnaround is kept.

Optional Feature:
- JTFRAME_DDIO_CHECK_EN
- Defined:
  - While in OUT, padio is compared against the value this block drives, at posedge (h_r) and negedge (l_r).
  - Any mismatch, including x/z bits, sets contention=1, sticky until rst_n.
  - Also issues $display with sim time.
- Not defined: contention is tied 0; no comparison logic.

Test Plan:
- Reset: rst_n=0 mid-OUT -> padio=z immediately; oe_ack=0, state IN, dout_vld=0 after release.
- Drive, TURN=1: oe_req=1 at posedge 0, datain_h=12'hA5A, datain_l=12'h5A5 held:
  - oe_ack=1 at posedge 2
  - padio=A5A during clk high, 5A5 during clk low from posedge 2 on.
- Capture: state IN, testbench drives 12'h123 before posedge and 12'h456 before negedge -> next posedge: dataout_h=123, dataout_l=456, dout_vld=1.
- Abort: TURN=3, oe_req=1 for 2 cycles then 0 -> returns to IN; oe_ack never 1; padio stays z.
- TURN_IN completion: TURN=2, oe_req toggles 1->0->1 in OUT:
  - pad z for 2 cycles, then IN for ≥1 cycle, then TURN_OUT
  - dout_vld=0 for pairs touching the turnaround.
- Contention (macro defined): in OUT, force padio bit 0 opposite to driven value -> contention=1 at next edge, remains 1 after force release until rst_n=0.

Source files
------------

// File: rtl/jtframe_ddio_bidir_if.sv
// Core-side signal bundle for jtframe_ddio_bidir: direction handshake, DDR data in/out, status.
interface jtframe_ddio_bidir_if #(
  parameter int unsigned W = 12
);
  logic         oe_req;
  logic         oe_ack;
  logic [W-1:0] datain_h;
  logic [W-1:0] datain_l;
  logic [W-1:0] dataout_h;
  logic [W-1:0] dataout_l;
  logic         dout_vld;
  logic         contention;

  modport master (
    output oe_req, datain_h, datain_l,
    input  oe_ack, dataout_h, dataout_l, dout_vld, contention
  );

  modport slave (
    input  oe_req, datain_h, datain_l,
    output oe_ack, dataout_h, dataout_l, dout_vld, contention
  );
endinterface

// File: rtl/jtframe_ddio_bidir.sv
// Parametrised DDR bidirectional pad model with direction FSM and bus-turnaround guard.
// Optional pad contention checker enabled by defining JTFRAME_DDIO_CHECK_EN.
module jtframe_ddio_bidir #(
  parameter int unsigned W    = 12,
  parameter int unsigned TURN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtframe_ddio_bidir_if.slave  bus,
  inout  wire  [W-1:0]         padio
);

  if (TURN > 15) begin : g_turn_range
    $error("jtframe_ddio_bidir: TURN=%0d exceeds the 4-bit turnaround counter", TURN);
  end

  localparam logic [3:0] TurnLast = (TURN == 0) ? 4'd0 : 4'(TURN - 1);

  typedef enum logic [1:0] {StIn, StTurnOut, StOut, StTurnIn} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         oe_ack_q;
  logic [W-1:0] h_r, l_r;
  logic [W-1:0] rise_q, fall_q;
  logic [W-1:0] dataout_h_q, dataout_l_q;
  logic         vld_rise_q, vld_fall_q, dout_vld_q;
  logic         drive_en;
  logic [W-1:0] drive;

  // State register doubles as the pad enable, so reset releases the pad without a clock edge.
  assign drive_en = (state_q == StOut);
  assign drive    = clk ? h_r : l_r;
  assign padio    = drive_en ? drive : {W{1'bz}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIn: begin
        if (bus.oe_req) begin
          state_d = (TURN == 0) ? StOut : StTurnOut;
          cnt_d   = 4'd0;
        end
      end
      StTurnOut: begin
        if (!bus.oe_req) begin
          state_d = StIn;
        end else if (cnt_q == TurnLast) begin
          state_d = StOut;
        end else begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
      end
      StOut: begin
        if (!bus.oe_req) begin
          state_d = (TURN == 0) ? StIn : StTurnIn;
          cnt_d   = 4'd0;
        end
      end
      StTurnIn: begin
        // Release always runs to completion so the far end sees the full guard time.
        if (cnt_q == TurnLast) begin
          state_d = StIn;
        end else begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
      end
      default: state_d = StIn;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIn;
      cnt_q       <= 4'd0;
      oe_ack_q    <= 1'b0;
      h_r         <= '0;
      l_r         <= '0;
      rise_q      <= '0;
      dataout_h_q <= '0;
      dataout_l_q <= '0;
      vld_rise_q  <= 1'b0;
      dout_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oe_ack_q    <= (state_d == StOut);
      h_r         <= bus.datain_h;
      l_r         <= bus.datain_l;
      rise_q      <= padio;
      dataout_h_q <= rise_q;
      dataout_l_q <= fall_q;
      // Direction in force just before this edge, i.e. while the rising sample was settling.
      vld_rise_q  <= (state_q == StIn);
      dout_vld_q  <= vld_fall_q;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q     <= '0;
      vld_fall_q <= 1'b0;
    end else begin
      fall_q     <= padio;
      vld_fall_q <= vld_rise_q && (state_q == StIn);
    end
  end

  assign bus.oe_ack    = oe_ack_q;
  assign bus.dataout_h = dataout_h_q;
  assign bus.dataout_l = dataout_l_q;
  assign bus.dout_vld  = dout_vld_q;

`ifdef JTFRAME_DDIO_CHECK_EN
  logic mismatch;
  logic cont_r_q, cont_f_q;

  // Any differing, x or z bit while driving counts as a fight on the pad.
  assign mismatch = drive_en && (padio !== drive);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_r_q <= 1'b0;
    end else if (mismatch) begin
      cont_r_q <= 1'b1;
      $display("%t jtframe_ddio_bidir: contention at posedge pad=%h drive=%h", $time, padio, drive);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_f_q <= 1'b0;
    end else if (mismatch) begin
      cont_f_q <= 1'b1;
      $display("%t jtframe_ddio_bidir: contention at negedge pad=%h drive=%h", $time, padio, drive);
    end
  end

  assign bus.contention = cont_r_q | cont_f_q;
`else
  assign bus.contention = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_ddio_bidir.sv
// Directed bench for jtframe_ddio_bidir: three instances (TURN=1,3,2) share one clock and reset.
// Pads are pulled up, so a released pad reads all ones.
module tb_jtframe_ddio_bidir;
  localparam int unsigned W = 12;
  localparam logic [W-1:0] Released = 12'hFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tri1 [W-1:0] pad1;
  tri1 [W-1:0] pad2;
  tri1 [W-1:0] pad3;
  logic         tb_oe1 = 1'b0;
  logic [W-1:0] tb_drv1 = '0;
  assign pad1 = tb_oe1 ? tb_drv1 : {W{1'bz}};

  jtframe_ddio_bidir_if #(.W(W)) if1 ();
  jtframe_ddio_bidir_if #(.W(W)) if2 ();
  jtframe_ddio_bidir_if #(.W(W)) if3 ();

  jtframe_ddio_bidir #(.W(W), .TURN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .padio(pad1));
  jtframe_ddio_bidir #(.W(W), .TURN(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .padio(pad2));
  jtframe_ddio_bidir #(.W(W), .TURN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3), .padio(pad3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic low();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    if1.oe_req = 0; if1.datain_h = '0; if1.datain_l = '0;
    if2.oe_req = 0; if2.datain_h = '0; if2.datain_l = '0;
    if3.oe_req = 0; if3.datain_h = '0; if3.datain_l = '0;
    rst_n = 0;
    #23;
    checks++; if (if1.oe_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", if1.oe_ack); end
    checks++; if (if1.dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", if1.dout_vld); end
    checks++; if (if1.dataout_h !== 12'h000) begin errors++; $display("FAIL reset_dout_h got %h want 000", if1.dataout_h); end
    checks++; if (if1.dataout_l !== 12'h000) begin errors++; $display("FAIL reset_dout_l got %h want 000", if1.dataout_l); end
    checks++; if (if1.contention !== 1'b0) begin errors++; $display("FAIL reset_contention got %b want 0", if1.contention); end
    checks++; if (pad1 !== Released) begin errors++; $display("FAIL reset_pad got %h want %h", pad1, Released); end
    rst_n = 1;
    tick();
    tick();
  endtask

  task automatic test_capture();
    tb_oe1 = 1; tb_drv1 = 12'h123;
    tick();
    tb_drv1 = 12'h456;
    low();
    tb_drv1 = 12'h789;
    tick();
    checks++; if (if1.dataout_h !== 12'h123) begin errors++; $display("FAIL capture_h got %h want 123", if1.dataout_h); end
    checks++; if (if1.dataout_l !== 12'h456) begin errors++; $display("FAIL capture_l got %h want 456", if1.dataout_l); end
    checks++; if (if1.dout_vld !== 1'b1) begin errors++; $display("FAIL capture_vld got %b want 1", if1.dout_vld); end
    tick();
    checks++; if (if1.dataout_h !== 12'h789) begin errors++; $display("FAIL capture_h2 got %h want 789", if1.dataout_h); end
    tb_oe1 = 0;
  endtask

  task automatic test_drive();
    tick();
    if1.oe_req = 1; if1.datain_h = 12'hA5A; if1.datain_l = 12'h5A5;
    tick();
    checks++; if (if1.oe_ack !== 1'b0) begin errors++; $display("FAIL drive_turn_ack got %b want 0", if1.oe_ack); end
    checks++; if (pad1 !== Released) begin errors++; $display("FAIL drive_turn_pad got %h want %h", pad1, Released); end
    tick();
    checks++; if (if1.oe_ack !== 1'b1) begin errors++; $display("FAIL drive_ack got %b want 1", if1.oe_ack); end
    checks++; if (pad1 !== 12'hA5A) begin errors++; $display("FAIL drive_pad_h got %h want A5A", pad1); end
    low();
    checks++; if (pad1 !== 12'h5A5) begin errors++; $display("FAIL drive_pad_l got %h want 5A5", pad1); end
    tick();
    checks++; if (pad1 !== 12'hA5A) begin errors++; $display("FAIL drive_pad_h2 got %h want A5A", pad1); end
  endtask

  task automatic test_contention();
`ifdef JTFRAME_DDIO_CHECK_EN
    // Bit 0 of A5A is 0, so pulling it to 1 fights the high-phase value.
    force pad1[0] = 1'b1;
    tick();
    checks++; if (if1.contention !== 1'b1) begin errors++; $display("FAIL contention_set got %b want 1", if1.contention); end
    release pad1[0];
    tick();
    tick();
    checks++; if (if1.contention !== 1'b1) begin errors++; $display("FAIL contention_sticky got %b want 1", if1.contention); end
`endif
  endtask

  task automatic test_reset_mid_out();
    #2;
    rst_n = 0;
    #1;
    checks++; if (pad1 !== Released) begin errors++; $display("FAIL midrst_pad got %h want %h", pad1, Released); end
    checks++; if (if1.oe_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b want 0", if1.oe_ack); end
    checks++; if (if1.contention !== 1'b0) begin errors++; $display("FAIL midrst_contention got %b want 0", if1.contention); end
    if1.oe_req = 0;
    tick();
    rst_n = 1;
    #1;
    checks++; if (if1.dout_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld got %b want 0", if1.dout_vld); end
    tick();
    checks++; if (if1.oe_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack_after got %b want 0", if1.oe_ack); end
    checks++; if (pad1 !== Released) begin errors++; $display("FAIL midrst_pad_after got %h want %h", pad1, Released); end
  endtask

  task automatic test_abort();
    tick();
    if3.oe_req = 1;
    for (int p = 1; p <= 6; p++) begin
      tick();
      checks++; if (if3.oe_ack !== 1'b0) begin errors++; $display("FAIL abort_ack_p%0d got %b want 0", p, if3.oe_ack); end
      checks++; if (pad3 !== Released) begin errors++; $display("FAIL abort_pad_p%0d got %h want %h", p, pad3, Released); end
      if (p == 2) if3.oe_req = 0;
      if (p == 3) if3.oe_req = 1;
    end
    tick();
    checks++; if (if3.oe_ack !== 1'b1) begin errors++; $display("FAIL abort_reissue_ack got %b want 1", if3.oe_ack); end
    if3.oe_req = 0;
    repeat (5) tick();
  endtask

  task automatic test_turn_in();
    if2.datain_h = 12'h3C3; if2.datain_l = 12'hC3C;
    tick();
    if2.oe_req = 1;
    tick();
    checks++; if (if2.dout_vld !== 1'b1) begin errors++; $display("FAIL turnin_vld_idle got %b want 1", if2.dout_vld); end
    tick();
    checks++; if (if2.dout_vld !== 1'b0) begin errors++; $display("FAIL turnin_vld_leave got %b want 0", if2.dout_vld); end
    checks++; if (if2.oe_ack !== 1'b0) begin errors++; $display("FAIL turnin_ack_p2 got %b want 0", if2.oe_ack); end
    tick();
    checks++; if (if2.oe_ack !== 1'b1) begin errors++; $display("FAIL turnin_ack_p3 got %b want 1", if2.oe_ack); end
    checks++; if (pad2 !== 12'h3C3) begin errors++; $display("FAIL turnin_pad_out got %h want 3C3", pad2); end
    if2.oe_req = 0;
    tick();
    checks++; if (pad2 !== Released) begin errors++; $display("FAIL turnin_pad_rel got %h want %h", pad2, Released); end
    if2.oe_req = 1;
    for (int p = 5; p <= 8; p++) begin
      tick();
      checks++; if (if2.oe_ack !== 1'b0) begin errors++; $display("FAIL turnin_ack_p%0d got %b want 0", p, if2.oe_ack); end
      checks++; if (pad2 !== Released) begin errors++; $display("FAIL turnin_pad_p%0d got %h want %h", p, pad2, Released); end
      checks++; if (if2.dout_vld !== 1'b0) begin errors++; $display("FAIL turnin_vld_p%0d got %b want 0", p, if2.dout_vld); end
    end
    tick();
    checks++; if (if2.oe_ack !== 1'b1) begin errors++; $display("FAIL turnin_reout_ack got %b want 1", if2.oe_ack); end
    if2.oe_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_drive();
    test_contention();
    test_reset_mid_out();
    test_abort();
    test_turn_in();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
